// File: rtl/ir_intf.sv
// ir_intf: periodic IR reflectance sequencer.
// Each round enables the emitters, lets them settle, converts the eight
// sensor channels through the shared A2D, then publishes all readings at
// once with a single-cycle IR_vld strobe.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   strt_cnv, chnnl   - A2D start pulse and channel select
//   cnv_cmplt, res    - A2D completion pulse and 12-bit result
//   IR_en             - emitter enable
//   IR_vld            - new reading set strobe
//   IR_R0..3, IR_L0..3 - right/left readings, inside out
module ir_intf #(
  parameter int unsigned PERIOD_CYCLES = 4096,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        IR_en,
  output logic        IR_vld,
  output logic [11:0] IR_R0,
  output logic [11:0] IR_R1,
  output logic [11:0] IR_R2,
  output logic [11:0] IR_R3,
  output logic [11:0] IR_L0,
  output logic [11:0] IR_L1,
  output logic [11:0] IR_L2,
  output logic [11:0] IR_L3
);

  localparam int unsigned TW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DW = 12;
  localparam int unsigned NCH = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [2:0]      idx_q, idx_d;
  logic [DW-1:0]   sh_q [NCH];
  logic [DW-1:0]   sh_d [NCH];
  logic [DW-1:0]   rd_q [NCH];
  logic [DW-1:0]   rd_d [NCH];
  logic            strt_q, strt_d;
  logic [2:0]      chnnl_q, chnnl_d;
  logic            en_q, en_d;
  logic            vld_q, vld_d;

  logic tick;
  logic settle_done;
  logic last_ch;

  // Free-running period timer; the wrap cycle is the round tick.
  assign tick        = (timer_q == TW'(PERIOD_CYCLES - 1));
  assign timer_d     = tick ? '0 : timer_q + TW'(1);
  assign settle_done = (settle_q == SW'(SETTLE_CYCLES - 1));
  assign last_ch     = (idx_q == 3'd7);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ticks outside IDLE are dropped (overrun).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tick) state_d = S_SETTLE;
      S_SETTLE: if (settle_done) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (cnv_cmplt) state_d = last_ch ? S_DONE : S_START;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values, decoded from the next state so every
  // output is registered yet lands in the cycle of its state.
  always_comb begin
    settle_d = '0;
    idx_d    = idx_q;
    sh_d     = sh_q;
    rd_d     = rd_q;

    if (state_q == S_SETTLE) settle_d = settle_q + SW'(1);
    if ((state_q == S_IDLE) && tick) idx_d = 3'd0;
    // Completions are only honoured while waiting for one.
    if ((state_q == S_WAIT) && cnv_cmplt) begin
      sh_d[idx_q] = res;
      if (!last_ch) idx_d = idx_q + 3'd1;
    end
    // Shadow set includes the final capture happening this same edge.
    if (state_d == S_DONE) rd_d = sh_d;

    strt_d  = (state_d == S_START);
    chnnl_d = strt_d ? idx_d : chnnl_q;
    en_d    = (state_d == S_SETTLE) || (state_d == S_START) || (state_d == S_WAIT);
    vld_d   = (state_d == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q  <= '0;
      settle_q <= '0;
      idx_q    <= '0;
      strt_q   <= 1'b0;
      chnnl_q  <= '0;
      en_q     <= 1'b0;
      vld_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        sh_q[i] <= '0;
        rd_q[i] <= '0;
      end
    end else begin
      timer_q  <= timer_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      strt_q   <= strt_d;
      chnnl_q  <= chnnl_d;
      en_q     <= en_d;
      vld_q    <= vld_d;
      for (int i = 0; i < NCH; i++) begin
        sh_q[i] <= sh_d[i];
        rd_q[i] <= rd_d[i];
      end
    end
  end

  assign strt_cnv = strt_q;
  assign chnnl    = chnnl_q;
  assign IR_en    = en_q;
  assign IR_vld   = vld_q;

  // Channel order alternates right/left, moving outward.
  assign IR_R0 = rd_q[0];
  assign IR_L0 = rd_q[1];
  assign IR_R1 = rd_q[2];
  assign IR_L1 = rd_q[3];
  assign IR_R2 = rd_q[4];
  assign IR_L2 = rd_q[5];
  assign IR_R3 = rd_q[6];
  assign IR_L3 = rd_q[7];

endmodule

// File: tb/tb_ir_intf.sv
// Testbench for ir_intf: A2D model with programmable latency, scoreboard of
// completed rounds, and a monitor checking timing, pulse widths and output hold.
module tb_ir_intf;

  localparam int unsigned PER = 64;
  localparam int unsigned SET = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = 12'h000;
  logic        strt_cnv, IR_en, IR_vld;
  logic [2:0]  chnnl;
  logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3;

  ir_intf #(.PERIOD_CYCLES(PER), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .IR_en(IR_en), .IR_vld(IR_vld),
    .IR_R0(IR_R0), .IR_R1(IR_R1), .IR_R2(IR_R2), .IR_R3(IR_R3),
    .IR_L0(IR_L0), .IR_L1(IR_L1), .IR_L2(IR_L2), .IR_L3(IR_L3)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] outs();
    return {IR_L3, IR_R3, IR_L2, IR_R2, IR_L1, IR_R1, IR_L0, IR_R0};
  endfunction

  function automatic logic [11:0] res_of(input int m, input logic [2:0] ch);
    case (m)
      0:       return 12'h100 + 12'(ch);
      1:       return 12'hFFF - 12'(ch);
      2:       return 12'h200 + 12'(ch) * 12'd17;
      3:       return 12'h3C0 + 12'(ch) * 12'd3;
      default: return 12'h5A0 + 12'(ch);
    endcase
  endfunction

  // A2D model and scoreboard producer.
  int          lat = 3;
  int          mode = 0;
  bit          spur_idle = 1'b0;
  bit          spur_start = 1'b0;
  int          a_cnt = 0;
  logic [2:0]  a_ch = 3'd0;
  logic [11:0] acc [8];
  logic [95:0] sb_q [$];

  initial begin
    for (int i = 0; i < 8; i++) acc[i] = 12'h000;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (!rst_q) begin
        a_cnt = 0;
        for (int i = 0; i < 8; i++) acc[i] = 12'h000;
      end else begin
        if (a_cnt > 0) begin
          a_cnt--;
          if (a_cnt == 0) begin
            cnv_cmplt = 1'b1;
            res = res_of(mode, a_ch);
            acc[a_ch] = res;
            if (a_ch == 3'd7)
              sb_q.push_back({acc[7], acc[6], acc[5], acc[4], acc[3], acc[2], acc[1], acc[0]});
          end
        end
        if (strt_cnv) begin
          a_cnt = lat;
          a_ch  = chnnl;
          if (spur_start) begin
            spur_start = 1'b0;
            cnv_cmplt = 1'b1;
            res = 12'hABC;
          end
        end else if (spur_idle) begin
          spur_idle = 1'b0;
          cnv_cmplt = 1'b1;
          res = 12'hABC;
        end
      end
    end
  end

  // Monitor: timing events, pulse widths, channel order, output hold, data.
  int          en_rise_cnt = 0, en_rise_cyc = 0;
  int          strt_cnt = 0, first_strt_cnt = 0, first_strt_cyc = 0, ch5_cnt = 0;
  int          vld_cnt = 0, vld_cyc = 0, prev_vld_cyc = 0;
  logic        en_p = 1'b0, strt_p = 1'b0, vld_p = 1'b0;
  logic [95:0] snap = '0;
  logic [95:0] exp_v;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_q) begin
        chk("rst_outs", outs(), 96'd0);
        chk("rst_ctl", 96'({strt_cnv, chnnl, IR_en, IR_vld}), 96'd0);
        snap = '0;
        en_p = 1'b0;
        strt_p = 1'b0;
        vld_p = 1'b0;
      end else begin
        if (IR_en && !en_p) begin
          en_rise_cnt++;
          en_rise_cyc = cyc;
          strt_cnt = 0;
        end
        if (strt_cnv) begin
          chk("strt_width", 96'(strt_p), 96'd0);
          chk("chnnl_order", 96'(chnnl), 96'(strt_cnt));
          if (strt_cnt == 0) begin
            first_strt_cyc = cyc;
            first_strt_cnt++;
          end
          if (chnnl == 3'd5) ch5_cnt++;
          strt_cnt++;
        end
        if (IR_vld) begin
          chk("vld_width", 96'(vld_p), 96'd0);
          chk("vld_en_low", 96'(IR_en), 96'd0);
          chk("strt_per_round", 96'(strt_cnt), 96'd8);
          chk("sb_avail", 96'(sb_q.size() != 0), 96'd1);
          if (sb_q.size() != 0) begin
            exp_v = sb_q.pop_front();
            chk("round_data", outs(), exp_v);
          end
          snap = outs();
          vld_cnt++;
          prev_vld_cyc = vld_cyc;
          vld_cyc = cyc;
        end else begin
          chk("hold", outs(), snap);
        end
        en_p = IR_en;
        strt_p = strt_cnv;
        vld_p = IR_vld;
      end
    end
  end

  function automatic int cnt_of(input int w);
    case (w)
      0:       return en_rise_cnt;
      1:       return first_strt_cnt;
      2:       return vld_cnt;
      default: return ch5_cnt;
    endcase
  endfunction

  // Bounded wait for the next occurrence of a monitored event.
  task automatic wait_evt(input string tag, input int w, input int lim);
    int n0;
    int i;
    n0 = cnt_of(w);
    i = 0;
    while (cnt_of(w) == n0 && i < lim) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk({tag, "_seen"}, 96'(cnt_of(w) != n0), 96'd1);
  endtask

  int rel = 0;
  int n_vld = 0;

  initial begin
    // Reset behaviour and first round timing.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    wait_evt("en1", 0, 200);
    chk("en_after_rst", 96'(en_rise_cyc - rel), 96'(PER));

    // Nominal round, L=3.
    wait_evt("strt1", 1, 50);
    chk("settle_len", 96'(first_strt_cyc - en_rise_cyc), 96'(SET));
    wait_evt("vld1", 2, 100);
    chk("conv_time", 96'(vld_cyc - first_strt_cyc), 96'd32);

    // Output hold across a second round with different data.
    mode = 1;
    wait_evt("vld2", 2, 100);
    chk("period2", 96'(vld_cyc - prev_vld_cyc), 96'(PER));

    // Spurious completions in IDLE and in the START cycle.
    mode = 2;
    spur_idle = 1'b1;
    spur_start = 1'b1;
    wait_evt("vld3", 2, 100);
    chk("period3", 96'(vld_cyc - prev_vld_cyc), 96'(PER));
    for (int k = 0; k < 8; k++) begin
      logic [95:0] o;
      o = outs();
      chk("no_spur", 96'(o[k*12 +: 12] == 12'hABC), 96'd0);
    end

    // Overrun with L=10: each round swallows one tick.
    lat = 10;
    mode = 3;
    wait_evt("vld4", 2, 300);
    wait_evt("vld5", 2, 300);
    chk("overrun_period", 96'(vld_cyc - prev_vld_cyc), 96'(2 * PER));

    // Reset while waiting on channel 5.
    lat = 3;
    mode = 4;
    wait_evt("ch5", 3, 300);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    n_vld = vld_cnt;
    @(negedge clk);
    #1;
    chk("mid_rst_en", 96'(IR_en), 96'd0);
    chk("mid_rst_outs", outs(), 96'd0);
    rst_n = 1'b1;
    rel = cyc;
    wait_evt("en_fresh", 0, 200);
    chk("en_after_mid_rst", 96'(en_rise_cyc - rel), 96'(PER));
    chk("no_vld_after_rst", 96'(vld_cnt - n_vld), 96'd0);
    wait_evt("vld6", 2, 100);
    chk("sb_drain", 96'(sb_q.size()), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
